// File: rtl/fantasticfft_pkg.sv
// Shared types for the 8-point FFT scheduler: fixed-point word, real and complex
// frames, and the gather/drain state encodings.
package fantasticfft_pkg;

   localparam int FX_INT  = 8;
   localparam int FX_FRAC = 8;
   localparam int FX_W    = FX_INT + FX_FRAC;
   localparam int FRAME_N = 8;

   typedef logic [FX_W-1:0] fixed_t;
   typedef fixed_t [FRAME_N-1:0] frame_t;

   typedef struct packed {
      frame_t re;
      frame_t im;
   } cframe_t;

   typedef enum logic {
      G_FILL = 1'b0,
      G_FULL = 1'b1
   } gather_state_t;

   typedef enum logic {
      D_IDLE  = 1'b0,
      D_DRAIN = 1'b1
   } drain_state_t;

   // Width helper that never returns 0, so depth-1 buffers still get a real pointer.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fantasticfft_frame_fifo.sv
// Output frame buffer: DEPTH complex frames with push/pop/count. No overflow
// protection here; the scheduler's credit scheme guarantees space before issue.
module fantasticfft_frame_fifo
   import fantasticfft_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PW    = clog2_min1(DEPTH),
   localparam int CW    = clog2_min1(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  cframe_t       push_data,
   input  logic          pop,
   output cframe_t       head,
   output logic [CW-1:0] count
);

   cframe_t         mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Frame storage is data only; validity lives entirely in count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fantasticfft_fft8_sched.sv
// Streaming scheduler around the 8-point FFT core: gathers 8 real samples,
// issues them with a credit check, buffers 16 result words and drains complex bins.
// Handshakes: a transfer happens on a rising clk edge when valid && ready are both
// high; the source holds valid and data stable until then, ready may depend on valid.
module fantasticfft_fft8_sched
   import fantasticfft_pkg::*;
#(
   parameter int  INT_SIZE     = FX_INT,
   parameter int  FRAC_SIZE    = FX_FRAC,
   parameter int  CORE_LATENCY = 4,
   parameter int  OUT_FRAMES   = 2,
   localparam int W            = INT_SIZE + FRAC_SIZE
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           core_valid,
   output logic [8*W-1:0] core_x,
   input  logic           core_result_valid,
   input  logic [8*W-1:0] core_y,
   input  logic [8*W-1:0] core_yi,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_re,
   output logic [W-1:0]   out_im,
   output logic [2:0]     out_idx,
   output logic           out_last,
   output logic           err_unexpected
);

   localparam int CW = clog2_min1(OUT_FRAMES + 1);
   localparam int BW = clog2_min1(CORE_LATENCY + 1);

   gather_state_t       g_state, g_next;
   drain_state_t        d_state, d_next;
   logic [2:0]          wr_idx;
   logic [6:0][W-1:0]   slot_q;
   logic [8*W-1:0]      core_x_q;
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       stored;
   logic [CW-1:0]       stored_next;
   logic [CW:0]         occupancy;
   logic [BW-1:0]       blank_cnt;
   logic [2:0]          rd_idx;
   logic                in_hs, out_hs;
   logic                issue, credit_ok;
   logic                res_ok, push, pop;
   logic                err_q;
   cframe_t             push_data, head;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;
   assign pop    = out_hs && (rd_idx == 3'd7);

   // A pop this cycle hands its slot straight back to a waiting frame.
   assign occupancy = {1'b0, inflight} + {1'b0, stored} - (CW + 1)'(pop);
   assign credit_ok = occupancy < (CW + 1)'(OUT_FRAMES);

   assign res_ok = core_result_valid && (blank_cnt == '0);
   assign push   = res_ok && (inflight != '0);

   always_comb begin
      stored_next = stored;
      case ({push, pop})
         2'b10:   stored_next = stored + 1'b1;
         2'b01:   stored_next = stored - 1'b1;
         default: stored_next = stored;
      endcase
   end

   // Gather FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_state  <= G_FILL;
         wr_idx   <= '0;
         slot_q   <= '0;
         core_x_q <= '0;
      end else begin
         g_state <= g_next;
         if (in_hs) begin
            if (wr_idx == 3'd7) core_x_q <= {in_data, slot_q};
            else                slot_q[wr_idx] <= in_data;
            wr_idx <= wr_idx + 3'd1;
         end
      end
   end

   always_comb begin
      g_next   = g_state;
      issue    = 1'b0;
      in_ready = 1'b0;
      case (g_state)
         G_FILL: begin
            in_ready = 1'b1;
            if (in_valid && (wr_idx == 3'd7)) g_next = G_FULL;
         end
         G_FULL: begin
            issue    = credit_ok;
            in_ready = credit_ok;
            if (credit_ok) g_next = G_FILL;
         end
         default: g_next = G_FILL;
      endcase
   end

   assign core_valid = issue;
   assign core_x     = core_x_q;

   // Credits, reset blanking and the sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight  <= '0;
         blank_cnt <= BW'(CORE_LATENCY);
         err_q     <= 1'b0;
      end else begin
         if (issue && !push)      inflight <= inflight + 1'b1;
         else if (push && !issue) inflight <= inflight - 1'b1;
         if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
         if (res_ok && (inflight == '0)) err_q <= 1'b1;
      end
   end

   assign err_unexpected = err_q;
   assign push_data.re   = core_y;
   assign push_data.im   = core_yi;

   fantasticfft_frame_fifo #(
      .DEPTH (OUT_FRAMES)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (stored)
   );

   // Drain FSM; looking at stored_next lets a fresh capture show up the next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_state <= D_IDLE;
         rd_idx  <= '0;
      end else begin
         d_state <= d_next;
         if (out_hs) rd_idx <= rd_idx + 3'd1;
      end
   end

   always_comb begin
      d_next = d_state;
      case (d_state)
         D_IDLE:  if (stored_next != '0) d_next = D_DRAIN;
         D_DRAIN: if (pop && (stored_next == '0)) d_next = D_IDLE;
         default: d_next = D_IDLE;
      endcase
   end

   assign out_valid = (d_state == D_DRAIN);
   assign out_re    = out_valid ? head.re[rd_idx] : '0;
   assign out_im    = out_valid ? head.im[rd_idx] : '0;
   assign out_idx   = rd_idx;
   assign out_last  = (rd_idx == 3'd7);

endmodule

// File: tb/tb_fantasticfft_fft8_sched.sv
// Directed bench for fantasticfft_fft8_sched with a latency-4 stand-in core and
// a scoreboard of expected frames and output bins.
module tb_fantasticfft_fft8_sched;

   localparam int W  = 16;
   localparam int EW = 2 * W + 3;

   typedef struct packed {
      logic [7:0][W-1:0] re;
      logic [7:0][W-1:0] im;
   } res_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid, in_ready;
   logic [W-1:0]   in_data;
   logic           core_valid;
   logic [8*W-1:0] core_x;
   logic           core_result_valid;
   logic [8*W-1:0] core_y, core_yi;
   logic           out_valid, out_ready;
   logic [W-1:0]   out_re, out_im;
   logic [2:0]     out_idx;
   logic           out_last;
   logic           err_unexpected;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fantasticfft_fft8_sched #(
      .INT_SIZE     (8),
      .FRAC_SIZE    (8),
      .CORE_LATENCY (4),
      .OUT_FRAMES   (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .core_valid        (core_valid),
      .core_x            (core_x),
      .core_result_valid (core_result_valid),
      .core_y            (core_y),
      .core_yi           (core_yi),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_re            (out_re),
      .out_im            (out_im),
      .out_idx           (out_idx),
      .out_last          (out_last),
      .err_unexpected    (err_unexpected)
   );

   // Stand-in core: impulse in x0 gives x0 in every real bin and zero imaginary.
   function automatic res_t core_model(input logic [8*W-1:0] x);
      logic [7:0][W-1:0] xa;
      res_t r;
      xa = x;
      for (int k = 0; k < 8; k++) begin
         r.re[k] = (k == 0) ? xa[0] : xa[0] + xa[k];
         r.im[k] = (k == 0) ? '0 : xa[k] - xa[8-k];
      end
      return r;
   endfunction

   logic [3:0] pv = '0;
   res_t       pd [4];
   logic       spur = 1'b0;

   always @(posedge clk) begin
      pv    <= {pv[2:0], core_valid};
      pd[0] <= core_model(core_x);
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
   end

   assign core_result_valid = pv[3] | spur;
   assign core_y            = pd[3].re;
   assign core_yi           = pd[3].im;

   // ---------------- scoreboard ----------------
   logic [EW-1:0]     exp_q[$];
   logic [8*W-1:0]    exp_frame_q[$];
   logic [7:0][W-1:0] acc_frame;
   res_t              exp_r;
   logic [EW-1:0]     e;
   logic [8*W-1:0]    ef;
   int acc_n = 0, last_acc8_cyc = 0, last_issue_cyc = 0, last_pop_cyc = 0;
   int iss_cnt = 0, out_cnt = 0, gap_cnt = 0;
   bit chk_issue_lat = 0, chk_period = 0, chk_gap = 0;

   task automatic check(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            acc_frame[acc_n] = in_data;
            if (acc_n == 7) begin
               exp_r = core_model(acc_frame);
               exp_frame_q.push_back(acc_frame);
               for (int k = 0; k < 8; k++) exp_q.push_back({exp_r.re[k], exp_r.im[k], 3'(k)});
               last_acc8_cyc = cyc;
               acc_n = 0;
            end else begin
               acc_n++;
            end
         end
         if (core_valid) begin
            if (exp_frame_q.size() > 0) ef = exp_frame_q.pop_front();
            else                        ef = 'x;
            check("core_x", core_x, ef);
            if (chk_issue_lat) check("issue_latency", cyc - last_acc8_cyc, 1);
            if (chk_period && iss_cnt > 0) check("issue_period", cyc - last_issue_cyc, 8);
            last_issue_cyc = cyc;
            iss_cnt++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            check("out_re", out_re, e[EW-1 -: W]);
            check("out_im", out_im, e[3 +: W]);
            check("out_idx", out_idx, e[2:0]);
            check("out_last", out_last, e[2:0] == 3'd7);
            if (out_last) last_pop_cyc = cyc;
            out_cnt++;
         end
         if (chk_gap && out_cnt > 0 && out_cnt < 128 && !out_valid) gap_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sample(input logic [W-1:0] d);
      int   n;
      logic rdy;
      in_valid = 1'b1;
      in_data  = d;
      n        = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      check("in_accept", rdy, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || exp_frame_q.size() > 0) && n < limit) begin
         tick();
         n++;
      end
      check("drain_done", exp_q.size() + exp_frame_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_core_valid"}, core_valid, 1'b0);
      check({tag, "_core_x"}, core_x, '0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_re"}, out_re, '0);
      check({tag, "_out_im"}, out_im, '0);
      check({tag, "_out_idx"}, out_idx, 3'd0);
      check({tag, "_out_last"}, out_last, 1'b0);
      check({tag, "_err"}, err_unexpected, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      logic [W-1:0] s25;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) tick();

      // impulse
      out_ready     = 1'b1;
      chk_issue_lat = 1;
      out_cnt       = 0;
      drive_sample(16'h0100);
      repeat (7) drive_sample(16'h0000);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("first_out_latency", cyc - last_acc8_cyc, 6);
      wait_drain(40);
      check("impulse_count", out_cnt, 8);

      // streaming throughput, including capture/pop collisions
      out_cnt    = 0;
      iss_cnt    = 0;
      gap_cnt    = 0;
      chk_period = 1;
      chk_gap    = 1;
      for (int i = 0; i < 128; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom_range(0, 65535));
         @(negedge clk);
         check("stream_in_ready", in_ready, 1'b1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_drain(100);
      chk_period = 0;
      chk_gap    = 0;
      check("stream_count", out_cnt, 128);
      check("stream_issues", iss_cnt, 16);
      check("stream_gaps", gap_cnt, 0);

      // backpressure
      out_ready     = 1'b0;
      chk_issue_lat = 0;
      out_cnt       = 0;
      iss_cnt       = 0;
      for (int i = 0; i < 24; i++) drive_sample(W'($urandom_range(0, 65535)));
      check("bp_issues", iss_cnt, 2);
      s25      = W'($urandom_range(0, 65535));
      in_valid = 1'b1;
      in_data  = s25;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_idx", out_idx, 3'd0);
         check("bp_out_re_hold", out_re, exp_q[0][EW-1 -: W]);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drive_sample(s25);
      check("bp_issue3", iss_cnt, 3);
      check("bp_issue_on_last_pop", last_issue_cyc, last_pop_cyc);
      for (int i = 0; i < 7; i++) drive_sample(W'($urandom_range(0, 65535)));
      wait_drain(100);
      check("bp_count", out_cnt, 32);

      // reset with a partial frame gathered and one frame in flight
      out_ready     = 1'b0;
      chk_issue_lat = 1;
      iss_cnt       = 0;
      for (int i = 0; i < 10; i++) drive_sample(W'($urandom_range(0, 65535)));
      check("rst_inflight_issue", iss_cnt, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      rst = 1'b0;
      exp_q.delete();
      exp_frame_q.delete();
      acc_n = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("blank_err", err_unexpected, 1'b0);
         check("blank_out_valid", out_valid, 1'b0);
      end
      tick();
      out_ready = 1'b1;
      out_cnt   = 0;
      for (int i = 0; i < 8; i++) drive_sample(W'($urandom_range(0, 65535)));
      wait_drain(40);
      check("post_reset_count", out_cnt, 8);

      // spurious result with nothing in flight
      out_cnt = 0;
      spur    = 1'b1;
      tick();
      spur = 1'b0;
      @(negedge clk);
      check("spur_err", err_unexpected, 1'b1);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("spur_err_sticky", err_unexpected, 1'b1);
         check("spur_out_valid", out_valid, 1'b0);
      end
      check("spur_out_count", out_cnt, 0);
      check("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
